// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch stage: FSM state encodings and the NOP word.
package if_pkg;

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  FILL     = 2'd1;
  localparam logic [1:0]  STREAM   = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/if_hold_buf.sv
// Stall hold register for the fetch stage: captures the BRAM word on the first stall cycle
// and drives inst_out, forcing NOP whenever the stage has no valid instruction.
module if_hold_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold_en,
  input  logic        inst_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out
);

  logic [31:0] hold_reg_q, hold_reg_d;
  logic        hold_valid_q, hold_valid_d;

  // The BRAM has already moved on to pc_out+1 during a stall, so only the first stall cycle holds the word for pc_out.
  always_comb begin
    hold_valid_d = hold_en;
    hold_reg_d   = hold_reg_q;
    if (hold_en && !hold_valid_q) begin
      hold_reg_d = imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg_q   <= NOP_INST;
      hold_valid_q <= 1'b0;
    end else begin
      hold_reg_q   <= hold_reg_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  always_comb begin
    inst_out = NOP_INST;
    if (inst_valid) begin
      inst_out = hold_valid_q ? hold_reg_q : imem_rdata;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the 1-cycle-latency instruction BRAM and
// feeds IF/ID. Define IF_FETCH_CNT_EN to build the delivered-instruction counter on fetch_count.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                         IMEM_ADDR_WIDTH = 9,
  parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic [31:0]                inst_out,
  output logic [IMEM_ADDR_WIDTH-1:0] pc_out,
  output logic                       inst_valid,
  output logic [31:0]                fetch_count
);

  logic [1:0]                 state_q, state_d;
  logic [IMEM_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [IMEM_ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                       advance;
  logic                       hold_en;

  // Priority: run=0 parks in IDLE, then redirect, then stall; a redirect always reloads fetch_pc.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_out_d   = pc_out_q;
    advance    = 1'b0;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end

    if (!run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = FILL;
        FILL, STREAM: begin
          if (redirect_valid) begin
            state_d = FILL;
          end else if (!stall) begin
            advance = 1'b1;
            state_d = STREAM;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (advance) begin
      pc_out_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + IMEM_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pc_out_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_out_q   <= pc_out_d;
    end
  end

  assign imem_addr  = fetch_pc_q;
  assign pc_out     = pc_out_q;
  assign inst_valid = (state_q == STREAM);
  assign hold_en    = (state_q == STREAM) && run && !redirect_valid && stall;

  if_hold_buf u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .hold_en    (hold_en),
    .inst_valid (inst_valid),
    .imem_rdata (imem_rdata),
    .inst_out   (inst_out)
  );

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // Only a STREAM cycle that actually hands its word to IF/ID counts as delivered.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (advance && (state_q == STREAM)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed per-cycle stimulus pushes the expected {pc, inst}
// of each valid cycle; a negedge monitor pops and compares whenever inst_valid is high.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        run;
  logic        stall;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [8:0]  pc_out;
  logic        inst_valid;
  logic [31:0] fetch_count;

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mem [0:511];
  int          checks;
  int          errors;
  int          exp_cnt;
  logic        mon_en;

  if_fetch_unit #(
    .IMEM_ADDR_WIDTH (9),
    .RESET_PC        (9'h000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_valid     (inst_valid),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction BRAM with one cycle of read latency.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + i;
  end
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name);
`ifdef IF_FETCH_CNT_EN
    checkOutput(name, fetch_count, exp_cnt);
`else
    checkOutput(name, fetch_count, 32'h0);
`endif
  endtask

  // Drives one cycle of inputs and records the output this cycle must show.
  task automatic applyStimulus(input logic r, input logic s, input logic rv, input logic [8:0] rpc,
                               input logic ev, input logic [8:0] epc);
    exp_t e;
    run            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (ev) begin
      e.pc   = epc;
      e.inst = 32'h1000_0000 + {23'b0, epc};
      exp_q.push_back(e);
      if (r && !s && !rv) exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got pc_out %h expected no valid output", pc_out);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("pc_out", {23'b0, pc_out}, {23'b0, mon_e.pc});
          checkOutput("inst_out", inst_out, mon_e.inst);
        end
      end else begin
        checkOutput("nop_when_invalid", inst_out, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    exp_cnt        = 0;
    mon_en         = 1'b0;
    reset          = 1'b1;
    run            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 9'h000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_inst_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("reset_imem_addr", {23'b0, imem_addr}, 32'h0);
    checkOutput("reset_pc_out", {23'b0, pc_out}, 32'h0);
    checkOutput("reset_inst_out", inst_out, 32'h0);
    checkOutput("reset_fetch_count", fetch_count, 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;

    $display("[TB] startup latency and streaming");
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    for (int p = 0; p < 5; p++) applyStimulus(1, 0, 0, 9'h000, 1, 9'(p));

    $display("[TB] three-cycle stall at pc 5");
    repeat (3) applyStimulus(1, 1, 0, 9'h000, 1, 9'h005);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h005);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h006);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h007);
    checkCount("count_after_stall");

    $display("[TB] redirect during stall and stall in FILL");
    applyStimulus(1, 1, 0, 9'h000, 1, 9'h008);
    applyStimulus(1, 1, 1, 9'h040, 1, 9'h008);
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h040);
    applyStimulus(1, 0, 1, 9'h050, 1, 9'h041);
    applyStimulus(1, 1, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h050);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h051);

    $display("[TB] run drop while holding, then re-run");
    applyStimulus(1, 1, 0, 9'h000, 1, 9'h052);
    applyStimulus(0, 1, 0, 9'h000, 1, 9'h052);
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h053);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h054);

    $display("[TB] redirect while parked, then wrap-around");
    applyStimulus(0, 0, 1, 9'h1FE, 1, 9'h055);
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h1FE);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h1FF);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h001);
    checkCount("count_after_wrap");

    $display("[TB] asynchronous reset mid-stream");
    reset = 1'b1;
    #2;
    checkOutput("async_inst_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("async_imem_addr", {23'b0, imem_addr}, 32'h0);
    checkOutput("async_inst_out", inst_out, 32'h0);
    checkOutput("async_fetch_count", fetch_count, 32'h0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = 0;

    $display("[TB] restart and counter window");
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h000);
    repeat (3) applyStimulus(1, 1, 0, 9'h000, 1, 9'h001);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h001);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h002);
    applyStimulus(1, 0, 1, 9'h100, 1, 9'h003);
    applyStimulus(1, 0, 0, 9'h000, 0, 9'h000);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h100);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h101);
    applyStimulus(1, 0, 0, 9'h000, 1, 9'h102);
`ifdef IF_FETCH_CNT_EN
    checkOutput("count_window", fetch_count, 32'd6);
`else
    checkOutput("count_window", fetch_count, 32'd0);
`endif

    applyStimulus(0, 0, 0, 9'h000, 1, 9'h103);
    applyStimulus(0, 0, 0, 9'h000, 0, 9'h000);
    checkCount("count_final");
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
